// File: rtl/breath_pkg.sv
// breath_pkg: state encoding and PWM period shared by the
// breathing sequencer and the PWM stage.
package breath_pkg;

  localparam logic [15:0] PWM_PERIOD = 16'd50000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

endpackage

// File: rtl/period_timer.sv
// period_timer: free-running PWM period counter with end flag
// and a registered tick on cycle 0 of each period.
module period_timer
  import breath_pkg::*;
#(
  parameter logic [15:0] MAX = PWM_PERIOD
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] cnt,
  output logic        period_end,
  output logic        period_tick
);

  assign period_end = (cnt == MAX - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= period_end ? '0 : cnt + 16'd1;
      period_tick <= period_end;
    end
  end

endmodule

// File: rtl/breath_ctrl.sv
// breath_ctrl: triangular duty ramp for the breathing lamp PWM.
// Define BREATH_HOLD_EN to add HOLD_HI/HOLD_LO dwell states.
module breath_ctrl
  import breath_pkg::*;
#(
  parameter logic [15:0] MAX_1MS = PWM_PERIOD,
  parameter logic [15:0] STEP    = 16'd50,
  parameter logic [15:0] UPD_MS  = 16'd1
`ifdef BREATH_HOLD_EN
  ,
  parameter logic [15:0] HOLD_MS = 16'd200
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] duty,
  output logic        rising,
  output logic        period_tick,
  output logic        cycle_done
);

  state_t      state, state_n;
  logic [15:0] duty_n;
  logic [15:0] upd_cnt;
  logic        period_end;
  logic        upd;
  logic        done_n;
  logic        do_up, do_dn;
  logic [16:0] up_sum;
  logic        up_sat, dn_sat;

  period_timer #(.MAX(MAX_1MS)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .cnt        (),
    .period_end (period_end),
    .period_tick(period_tick)
  );

  assign upd    = period_end && (upd_cnt == UPD_MS - 16'd1);
  assign up_sum = {1'b0, duty} + {1'b0, STEP};
  assign up_sat = (up_sum >= {1'b0, MAX_1MS});
  assign dn_sat = (duty <= STEP);

`ifdef BREATH_HOLD_EN
  logic [15:0] hold_cnt;
  logic        hold_last;

  assign hold_last = (hold_cnt == HOLD_MS - 16'd1);
  assign rising    = (state == RISE) || (state == HOLD_HI);

  // Hold exit performs the first step of the next ramp so the
  // plateau lasts exactly HOLD_MS periods.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hold_cnt <= '0;
    else if (state_n != state)
      hold_cnt <= '0;
    else if (period_end && (state == HOLD_HI || state == HOLD_LO))
      hold_cnt <= hold_cnt + 16'd1;
  end
`else
  assign rising = (state == RISE);
`endif

  always_comb begin
    state_n = state;
    duty_n  = duty;
    done_n  = 1'b0;
    do_up   = 1'b0;
    do_dn   = 1'b0;
    unique case (state)
      IDLE: begin
        duty_n = '0;
        if (period_end && en)
          state_n = RISE;
      end
      RISE: begin
        if (upd)
          do_up = 1'b1;
        else if (period_end && !en)
          state_n = FALL;
      end
      FALL: begin
        if (upd)
          do_dn = 1'b1;
      end
`ifdef BREATH_HOLD_EN
      HOLD_HI: begin
        if (period_end && (!en || hold_last))
          do_dn = 1'b1;
      end
      HOLD_LO: begin
        if (period_end) begin
          if (!en)
            state_n = IDLE;
          else if (hold_last)
            do_up = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    if (do_up) begin
      duty_n = up_sat ? MAX_1MS : up_sum[15:0];
`ifdef BREATH_HOLD_EN
      state_n = !en ? FALL : (up_sat ? HOLD_HI : RISE);
`else
      state_n = (!en || up_sat) ? FALL : RISE;
`endif
    end

    if (do_dn) begin
      if (dn_sat) begin
        duty_n = '0;
        done_n = 1'b1;
`ifdef BREATH_HOLD_EN
        state_n = en ? HOLD_LO : IDLE;
`else
        state_n = en ? RISE : IDLE;
`endif
      end else begin
        duty_n  = duty - STEP;
        state_n = FALL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      duty       <= '0;
      cycle_done <= 1'b0;
      upd_cnt    <= '0;
    end else begin
      state      <= state_n;
      duty       <= duty_n;
      cycle_done <= done_n;
      if (state == IDLE)
        upd_cnt <= '0;
      else if (period_end)
        upd_cnt <= upd ? '0 : upd_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_breath_ctrl.sv
// tb_breath_ctrl: directed bench for breath_ctrl, MAX=10 STEP=3.
// Covers both builds of BREATH_HOLD_EN.
module tb_breath_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [15:0] duty;
  logic        rising;
  logic        period_tick;
  logic        cycle_done;

  int compared   = 0;
  int mismatched = 0;
  int done_seen  = 0;

  logic        align_on  = 1'b0;
  logic [15:0] prev_duty = '0;

`ifdef BREATH_HOLD_EN
  localparam int NB       = 12;
  localparam int DONE_IDX = 9;
  logic [15:0] exp_duty [NB] = '{0, 3, 6, 9, 10, 10, 7, 4, 1, 0, 0, 3};
  logic        exp_rise [NB] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
`else
  localparam int NB       = 10;
  localparam int DONE_IDX = 8;
  logic [15:0] exp_duty [NB] = '{0, 3, 6, 9, 10, 7, 4, 1, 0, 3};
  logic        exp_rise [NB] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
`endif

  logic [15:0] dis_duty [6] = '{9, 6, 3, 0, 0, 0};

  always #5 clk = ~clk;

  breath_ctrl #(
    .MAX_1MS(16'd10),
    .STEP   (16'd3),
    .UPD_MS (16'd1)
`ifdef BREATH_HOLD_EN
    ,
    .HOLD_MS(16'd2)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .duty       (duty),
    .rising     (rising),
    .period_tick(period_tick),
    .cycle_done (cycle_done)
  );

  // duty may only move on the cycle where the PWM counter is 0
  always @(negedge clk) begin
    if (align_on) begin
      compared++;
      if (duty !== prev_duty && period_tick !== 1'b1) begin
        mismatched++;
        $display("FAIL align: duty %0d -> %0d with period_tick=%b",
                 prev_duty, duty, period_tick);
      end
    end
    prev_duty = duty;
  end

  task automatic wait_tick(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (cycle_done === 1'b1) done_seen++;
      if (period_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL %s: no period_tick within 25 clocks", tag);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    en  = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({duty, rising, period_tick, cycle_done} !== 19'd0) begin
      mismatched++;
      $display("FAIL reset_hold: duty=%0d rising=%b tick=%b done=%b, want all 0",
               duty, rising, period_tick, cycle_done);
    end
    rst = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      compared++;
      if (period_tick !== ((k % 10) == 0)) begin
        mismatched++;
        $display("FAIL reset_tick clk %0d: tick=%b want %b",
                 k, period_tick, ((k % 10) == 0));
      end
      compared++;
      if (duty !== 16'd0 || rising !== 1'b0 || cycle_done !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_idle clk %0d: duty=%0d rising=%b done=%b want 0/0/0",
                 k, duty, rising, cycle_done);
      end
    end
  endtask

  task automatic test_breath;
    bit ok;
    en = 1'b1;
    done_seen = 0;
    for (int i = 0; i < NB; i++) begin
      wait_tick("breath", ok);
      if (!ok) return;
      compared++;
      if (duty !== exp_duty[i]) begin
        mismatched++;
        $display("FAIL breath_duty[%0d]: got %0d want %0d", i, duty, exp_duty[i]);
      end
      compared++;
      if (rising !== exp_rise[i]) begin
        mismatched++;
        $display("FAIL breath_rising[%0d]: got %b want %b", i, rising, exp_rise[i]);
      end
      compared++;
      if (cycle_done !== (i == DONE_IDX)) begin
        mismatched++;
        $display("FAIL breath_done[%0d]: got %b want %b", i, cycle_done, (i == DONE_IDX));
      end
    end
    compared++;
    if (done_seen != 1) begin
      mismatched++;
      $display("FAIL breath_done_count: got %0d want 1", done_seen);
    end
  endtask

  task automatic test_disable;
    bit ok;
    wait_tick("disable_pre", ok);
    if (!ok) return;
    compared++;
    if (duty !== 16'd6 || rising !== 1'b1) begin
      mismatched++;
      $display("FAIL disable_pre: duty=%0d rising=%b want 6/1", duty, rising);
    end
    en = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      wait_tick("disable", ok);
      if (!ok) return;
      compared++;
      if (duty !== dis_duty[i] || rising !== 1'b0) begin
        mismatched++;
        $display("FAIL disable_duty[%0d]: duty=%0d rising=%b want %0d/0",
                 i, duty, rising, dis_duty[i]);
      end
      compared++;
      if (cycle_done !== (i == 3)) begin
        mismatched++;
        $display("FAIL disable_done[%0d]: got %b want %b", i, cycle_done, (i == 3));
      end
    end
    compared++;
    if (done_seen != 1) begin
      mismatched++;
      $display("FAIL disable_done_count: got %0d want 1", done_seen);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    bit found;
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      wait_tick("async_seek", ok);
      if (!ok) return;
      if (duty === 16'd7) found = 1'b1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL async_seek: duty never reached 7, last %0d", duty);
      return;
    end
    repeat (3) @(negedge clk);
    align_on = 1'b0;
    #2 rst = 1'b0;
    #1;
    compared++;
    if ({duty, rising, period_tick, cycle_done} !== 19'd0) begin
      mismatched++;
      $display("FAIL async_reset: duty=%0d rising=%b tick=%b done=%b want all 0",
               duty, rising, period_tick, cycle_done);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    align_on = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 9) begin
        compared++;
        if (rising !== 1'b0 || duty !== 16'd0 || period_tick !== 1'b0) begin
          mismatched++;
          $display("FAIL restart_idle: rising=%b duty=%0d tick=%b want 0/0/0",
                   rising, duty, period_tick);
        end
      end
      if (k == 10) begin
        compared++;
        if (period_tick !== 1'b1 || rising !== 1'b1 || duty !== 16'd0) begin
          mismatched++;
          $display("FAIL restart_rise: tick=%b rising=%b duty=%0d want 1/1/0",
                   period_tick, rising, duty);
        end
      end
      if (k == 20) begin
        compared++;
        if (duty !== 16'd3) begin
          mismatched++;
          $display("FAIL restart_step: duty=%0d want 3", duty);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    align_on = 1'b1;
    test_breath();
    test_disable();
    test_async_reset();
    align_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
